// File: rtl/prbs_pkg.sv
// Shared definitions for the PRBS7 receive checker: constants, lock FSM states
// and the 64-bit sequence extension used to predict the next word.
package prbs_pkg;

  localparam int          PRBS7_LEN       = 127;
  localparam logic [63:0] DEF_MARKER_MASK = 64'h8000_8000_8000_8000;

  typedef enum logic {
    HUNT   = 1'b0,
    LOCKED = 1'b1
  } prbs_state_e;

  // seed7[0] is the oldest bit. Applies s[i+7] = s[i] ^ s[i+1] for 64 more bits.
  function automatic logic [63:0] prbs7_next64(input logic [6:0] seed7);
    logic [70:0] b;
    b        = '0;
    b[6:0]   = seed7;
    for (int i = 7; i < 71; i++) begin
      b[i] = b[i-7] ^ b[i-6];
    end
    return b[70:7];
  endfunction

endpackage

// File: rtl/popcount64.sv
// Registered population count of a 64-bit word; result holds while en is low.
module popcount64 (
  input  logic        clk,
  input  logic        rst,
  input  logic        en,
  input  logic [63:0] data,
  output logic [6:0]  cnt
);

  logic [6:0] sum;
  logic [6:0] cnt_d, cnt_q;

  always_comb begin
    sum = '0;
    for (int i = 0; i < 64; i++) begin
      sum = sum + 7'(data[i]);
    end
    cnt_d = en ? sum : cnt_q;
  end

  always_ff @(posedge clk) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

  assign cnt = cnt_q;

endmodule

// File: rtl/prbs_checker.sv
// Receive-side PRBS7 checker: descramble, self-seeded prediction, lock FSM and
// saturating BER counters. Word results appear two cycles after data_in.
module prbs_checker
  import prbs_pkg::*;
#(
  parameter logic [63:0] MARKER_MASK    = DEF_MARKER_MASK,
  parameter int          LOCK_GOOD_CNT  = 16,
  parameter int          UNLOCK_BAD_CNT = 4,
  parameter int          CNT_W          = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [63:0]       data_in,
  input  logic              data_valid,
  input  logic              clear_cnt,
  output logic              locked,
  output logic              err_word,
  output logic [6:0]        err_bits,
  output logic [CNT_W-1:0]  bit_err_cnt,
  output logic [CNT_W-1:0]  word_err_cnt,
  output logic [47:0]       word_cnt,
  output prbs_state_e       dbg_state
);

  localparam int GW = $clog2(LOCK_GOOD_CNT + 1);
  localparam int BW = $clog2(UNLOCK_BAD_CNT + 1);

  // data_valid qualifies data_in; there is no backpressure, idle cycles only stall.
  logic [63:0]      w, exp_word;
  logic             zero_lock;
  logic [6:0]       seed_d, seed_q;
  logic             have_seed_d, have_seed_q;
  logic [63:0]      mism_d, mism_q;
  logic             s1_chk_d, s1_chk_q;
  logic             s2_chk_d, s2_chk_q;
  logic             err_word_d, err_word_q;
  logic [6:0]       pop_cnt;
  prbs_state_e      state_d, state_q;
  logic [GW-1:0]    good_d, good_q;
  logic [BW-1:0]    bad_d, bad_q;
  logic [CNT_W-1:0] bit_cnt_d, bit_cnt_q;
  logic [CNT_W-1:0] werr_cnt_d, werr_cnt_q;
  logic [47:0]      wcnt_d, wcnt_q;

  function automatic logic [CNT_W-1:0] sat_add(input logic [CNT_W-1:0] a,
                                               input logic [6:0]       b);
    logic [CNT_W:0] s;
    s = {1'b0, a} + {{(CNT_W-6){1'b0}}, b};
    return s[CNT_W] ? '1 : s[CNT_W-1:0];
  endfunction

  always_comb begin
    w           = data_in ^ MARKER_MASK;
    exp_word    = prbs7_next64(seed_q);
    zero_lock   = (seed_q == '0) || (w == '0);
    seed_d      = seed_q;
    have_seed_d = have_seed_q;
    mism_d      = mism_q;
    s1_chk_d    = data_valid && have_seed_q;
    if (data_valid) begin
      // A zero seed or zero word would lock the LFSR at zero; force a full-word error.
      mism_d      = zero_lock ? '1 : (w ^ exp_word);
      seed_d      = w[63:57];
      have_seed_d = 1'b1;
    end
    err_word_d = s1_chk_q && (mism_q != '0);
    s2_chk_d   = s1_chk_q;
  end

  popcount64 u_popcount (
    .clk  (clk),
    .rst  (rst),
    .en   (s1_chk_q),
    .data (mism_q),
    .cnt  (pop_cnt)
  );

  always_comb begin
    state_d    = state_q;
    good_d     = good_q;
    bad_d      = bad_q;
    bit_cnt_d  = bit_cnt_q;
    werr_cnt_d = werr_cnt_q;
    wcnt_d     = wcnt_q;
    if (s2_chk_q) begin
      // Counting uses the state before this update, so the locking word is excluded.
      if (state_q == LOCKED) begin
        bit_cnt_d  = sat_add(bit_cnt_q, pop_cnt);
        werr_cnt_d = sat_add(werr_cnt_q, {6'd0, err_word_q});
        if (wcnt_q != '1) wcnt_d = wcnt_q + 48'd1;
      end
      case (state_q)
        HUNT: begin
          if (err_word_q) begin
            good_d = '0;
          end else if (good_q == GW'(LOCK_GOOD_CNT - 1)) begin
            state_d = LOCKED;
            good_d  = '0;
            bad_d   = '0;
          end else begin
            good_d = good_q + GW'(1);
          end
        end
        LOCKED: begin
          if (!err_word_q) begin
            bad_d = '0;
          end else if (bad_q == BW'(UNLOCK_BAD_CNT - 1)) begin
            state_d = HUNT;
            good_d  = '0;
            bad_d   = '0;
          end else begin
            bad_d = bad_q + BW'(1);
          end
        end
        default: state_d = HUNT;
      endcase
    end
    if (clear_cnt) begin
      bit_cnt_d  = '0;
      werr_cnt_d = '0;
      wcnt_d     = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      seed_q      <= '0;
      have_seed_q <= 1'b0;
      mism_q      <= '0;
      s1_chk_q    <= 1'b0;
      s2_chk_q    <= 1'b0;
      err_word_q  <= 1'b0;
      state_q     <= HUNT;
      good_q      <= '0;
      bad_q       <= '0;
      bit_cnt_q   <= '0;
      werr_cnt_q  <= '0;
      wcnt_q      <= '0;
    end else begin
      seed_q      <= seed_d;
      have_seed_q <= have_seed_d;
      mism_q      <= mism_d;
      s1_chk_q    <= s1_chk_d;
      s2_chk_q    <= s2_chk_d;
      err_word_q  <= err_word_d;
      state_q     <= state_d;
      good_q      <= good_d;
      bad_q       <= bad_d;
      bit_cnt_q   <= bit_cnt_d;
      werr_cnt_q  <= werr_cnt_d;
      wcnt_q      <= wcnt_d;
    end
  end

  assign locked       = (state_q == LOCKED);
  assign dbg_state    = state_q;
  assign err_word     = err_word_q;
  assign err_bits     = pop_cnt;
  assign bit_err_cnt  = bit_cnt_q;
  assign word_err_cnt = werr_cnt_q;
  assign word_cnt     = wcnt_q;

endmodule
